// File: rtl/ubuf_wr_arbiter.sv
// Write-port arbiter in front of the unified buffer input memory: queues VPU writes,
// slots them into cycles without an AXI IMEM write, and stalls AXI to bound VPU starvation.
module ubuf_wr_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s_axi_en,
    input  logic                    s_axi_we,
    input  logic [15:0]             s_axi_addr,
    input  logic [63:0]             s_axi_wdata,
    output logic                    s_axi_ready,

    output logic                    axi_ubuf_en,
    output logic                    axi_ubuf_we,
    output logic [15:0]             axi_ubuf_addr,
    output logic [63:0]             axi_ubuf_wdata,

    input  logic                    vpu_wr_valid,
    output logic                    vpu_wr_ready,
    input  logic [9:0]              vpu_wr_addr,
    input  logic [1:0]              vpu_wr_size,
    input  logic [7:0][3:0][15:0]   vpu_wr_data,

    output logic                    ub_wr_VPU_en,
    output logic [9:0]              ub_wr_VPU_addr_in,
    output logic [1:0]              ub_wr_VPU_size_in,
    output logic [7:0][3:0][15:0]   ub_wr_VPU_data_in,

    output logic                    vpu_wr_idle,
    output logic [LVL_W-1:0]        fifo_level
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [9:0]              q_addr [FIFO_DEPTH];
    logic [1:0]              q_size [FIFO_DEPTH];
    logic [7:0][3:0][15:0]   q_data [FIFO_DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [STARVE_W-1:0] starve_cnt;
    logic                force_q;

    logic                empty;
    logic                imem_wr;
    logic                imem_grant;
    logic                drain;
    logic                push;
    logic [LVL_W-1:0]    level_next;
    logic [STARVE_W-1:0] starve_next;

    assign empty      = (fifo_level == '0);
    assign imem_wr    = s_axi_en && s_axi_we &&
                        (s_axi_addr >= 16'h2000) && (s_axi_addr <= 16'h27FF);
    assign s_axi_ready = !rst && !force_q;
    assign imem_grant = imem_wr && s_axi_ready;
    // rst gates the drain so no stale entry reaches the buffer during a reset cycle
    assign drain      = !rst && !empty && !imem_grant;
    assign vpu_wr_ready = !rst && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push       = vpu_wr_valid && vpu_wr_ready && (vpu_wr_size != 2'b00);

    assign axi_ubuf_en    = s_axi_en && s_axi_ready;
    assign axi_ubuf_we    = s_axi_we;
    assign axi_ubuf_addr  = s_axi_addr;
    assign axi_ubuf_wdata = s_axi_wdata;

    assign ub_wr_VPU_en      = drain;
    assign ub_wr_VPU_addr_in = empty ? '0 : q_addr[rd_ptr];
    assign ub_wr_VPU_size_in = empty ? '0 : q_size[rd_ptr];
    assign ub_wr_VPU_data_in = empty ? '0 : q_data[rd_ptr];

    always_comb begin
        level_next = fifo_level;
        if (push && !drain) begin
            level_next = fifo_level + LVL_W'(1);
        end else if (!push && drain) begin
            level_next = fifo_level - LVL_W'(1);
        end
    end

    // Starvation counter only runs while the head is being blocked by granted IMEM writes
    always_comb begin
        starve_next = starve_cnt;
        if (drain || empty) begin
            starve_next = '0;
        end else if (imem_grant && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
            starve_next = starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            starve_cnt  <= '0;
            force_q     <= 1'b0;
            vpu_wr_idle <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (drain) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            fifo_level  <= level_next;
            starve_cnt  <= starve_next;
            force_q     <= (level_next != '0) && (starve_next == STARVE_W'(STARVE_LIMIT));
            vpu_wr_idle <= (level_next == '0);
        end
    end

    // Entry storage needs no reset: the pointers and level decide what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= vpu_wr_addr;
            q_size[wr_ptr] <= vpu_wr_size;
            q_data[wr_ptr] <= vpu_wr_data;
        end
    end

    a_no_collision: assert property (@(posedge clk) disable iff (rst)
        !(ub_wr_VPU_en && imem_wr && s_axi_ready));

    a_level_bound: assert property (@(posedge clk) disable iff (rst)
        fifo_level <= LVL_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_ubuf_wr_arbiter.sv
// Directed-vector bench for ubuf_wr_arbiter with default parameters (depth 4, starve limit 8).
module tb_ubuf_wr_arbiter;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_axi_en, s_axi_we;
    logic [15:0]           s_axi_addr;
    logic [63:0]           s_axi_wdata;
    logic                  s_axi_ready;
    logic                  axi_ubuf_en, axi_ubuf_we;
    logic [15:0]           axi_ubuf_addr;
    logic [63:0]           axi_ubuf_wdata;
    logic                  vpu_wr_valid, vpu_wr_ready;
    logic [9:0]            vpu_wr_addr;
    logic [1:0]            vpu_wr_size;
    logic [7:0][3:0][15:0] vpu_wr_data;
    logic                  ub_wr_VPU_en;
    logic [9:0]            ub_wr_VPU_addr_in;
    logic [1:0]            ub_wr_VPU_size_in;
    logic [7:0][3:0][15:0] ub_wr_VPU_data_in;
    logic                  vpu_wr_idle;
    logic [2:0]            fifo_level;

    int vectors = 0;
    int miscompares = 0;

    ubuf_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .s_axi_en(s_axi_en), .s_axi_we(s_axi_we), .s_axi_addr(s_axi_addr),
        .s_axi_wdata(s_axi_wdata), .s_axi_ready(s_axi_ready),
        .axi_ubuf_en(axi_ubuf_en), .axi_ubuf_we(axi_ubuf_we),
        .axi_ubuf_addr(axi_ubuf_addr), .axi_ubuf_wdata(axi_ubuf_wdata),
        .vpu_wr_valid(vpu_wr_valid), .vpu_wr_ready(vpu_wr_ready),
        .vpu_wr_addr(vpu_wr_addr), .vpu_wr_size(vpu_wr_size), .vpu_wr_data(vpu_wr_data),
        .ub_wr_VPU_en(ub_wr_VPU_en), .ub_wr_VPU_addr_in(ub_wr_VPU_addr_in),
        .ub_wr_VPU_size_in(ub_wr_VPU_size_in), .ub_wr_VPU_data_in(ub_wr_VPU_data_in),
        .vpu_wr_idle(vpu_wr_idle), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mk_data(input logic [15:0] tag);
        return {32{tag}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_axi_en = 1'b0; s_axi_we = 1'b0; s_axi_addr = '0; s_axi_wdata = '0;
        vpu_wr_valid = 1'b0; vpu_wr_addr = '0; vpu_wr_size = 2'b00; vpu_wr_data = '0;
    endtask

    task automatic axi_write(input logic [15:0] a);
        s_axi_en = 1'b1; s_axi_we = 1'b1; s_axi_addr = a; s_axi_wdata = {48'h0, a};
    endtask

    task automatic vpu_push(input logic [9:0] a, input logic [1:0] sz, input logic [15:0] tag);
        vpu_wr_valid = 1'b1; vpu_wr_addr = a; vpu_wr_size = sz; vpu_wr_data = mk_data(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        axi_write(16'h2000);
        vpu_push(10'h001, 2'b01, 16'h0001);
        step();
        #2;
        vectors++; if (s_axi_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_s_axi_ready got %0b want 0", s_axi_ready); end
        vectors++; if (vpu_wr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_vpu_wr_ready got %0b want 0", vpu_wr_ready); end
        vectors++; if (axi_ubuf_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_axi_ubuf_en got %0b want 0", axi_ubuf_en); end
        vectors++; if (fifo_level !== 3'd0 || vpu_wr_idle !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_level_idle got %0d/%0b want 0/1", fifo_level, vpu_wr_idle); end
        vectors++; if (ub_wr_VPU_en !== 1'b0 || ub_wr_VPU_addr_in !== 10'h0) begin miscompares++; $display("[TB] FAIL rst_vpu_out got en=%0b addr=%0h want 0/0", ub_wr_VPU_en, ub_wr_VPU_addr_in); end
        rst = 1'b0;
        idle_inputs();
        #2;
        vectors++; if (s_axi_ready !== 1'b1 || vpu_wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_ready got %0b/%0b want 1/1", s_axi_ready, vpu_wr_ready); end
        step();
    endtask

    task automatic test_lone_write();
        vpu_push(10'h005, 2'b01, 16'hA005);
        #2;
        vectors++; if (vpu_wr_ready !== 1'b1 || ub_wr_VPU_en !== 1'b0) begin miscompares++; $display("[TB] FAIL lone_accept got ready=%0b en=%0b want 1/0", vpu_wr_ready, ub_wr_VPU_en); end
        step();
        idle_inputs();
        #2;
        vectors++; if (ub_wr_VPU_en !== 1'b1) begin miscompares++; $display("[TB] FAIL lone_en got %0b want 1", ub_wr_VPU_en); end
        vectors++; if (ub_wr_VPU_addr_in !== 10'h005 || ub_wr_VPU_size_in !== 2'b01) begin miscompares++; $display("[TB] FAIL lone_head got %0h/%0b want 005/01", ub_wr_VPU_addr_in, ub_wr_VPU_size_in); end
        vectors++; if (ub_wr_VPU_data_in !== mk_data(16'hA005)) begin miscompares++; $display("[TB] FAIL lone_data got %0h want %0h", ub_wr_VPU_data_in[0][0], 16'hA005); end
        vectors++; if (fifo_level !== 3'd1 || vpu_wr_idle !== 1'b0) begin miscompares++; $display("[TB] FAIL lone_level got %0d/%0b want 1/0", fifo_level, vpu_wr_idle); end
        step();
        #2;
        vectors++; if (vpu_wr_idle !== 1'b1 || fifo_level !== 3'd0 || ub_wr_VPU_en !== 1'b0) begin miscompares++; $display("[TB] FAIL lone_done got idle=%0b lvl=%0d en=%0b want 1/0/0", vpu_wr_idle, fifo_level, ub_wr_VPU_en); end
        vectors++; if (ub_wr_VPU_addr_in !== 10'h0 || ub_wr_VPU_size_in !== 2'b00) begin miscompares++; $display("[TB] FAIL lone_zero got %0h/%0b want 0/0", ub_wr_VPU_addr_in, ub_wr_VPU_size_in); end
    endtask

    task automatic test_starvation();
        int grants = 0;
        axi_write(16'h2008);
        vpu_push(10'h015, 2'b10, 16'hB015);
        step();
        vpu_wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (s_axi_ready === 1'b1 && axi_ubuf_en === 1'b1 && ub_wr_VPU_en === 1'b0) grants++;
            step();
        end
        vectors++; if (grants != 8) begin miscompares++; $display("[TB] FAIL starve_grants got %0d want 8", grants); end
        #2;
        vectors++; if (s_axi_ready !== 1'b0 || axi_ubuf_en !== 1'b0) begin miscompares++; $display("[TB] FAIL starve_stall got ready=%0b en=%0b want 0/0", s_axi_ready, axi_ubuf_en); end
        vectors++; if (ub_wr_VPU_en !== 1'b1 || ub_wr_VPU_addr_in !== 10'h015 || ub_wr_VPU_size_in !== 2'b10) begin miscompares++; $display("[TB] FAIL starve_drain got en=%0b addr=%0h size=%0b want 1/015/10", ub_wr_VPU_en, ub_wr_VPU_addr_in, ub_wr_VPU_size_in); end
        step();
        #2;
        vectors++; if (s_axi_ready !== 1'b1 || axi_ubuf_en !== 1'b1 || ub_wr_VPU_en !== 1'b0 || fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL starve_resume got ready=%0b en=%0b ven=%0b lvl=%0d want 1/1/0/0", s_axi_ready, axi_ubuf_en, ub_wr_VPU_en, fifo_level); end
        idle_inputs();
        step();
    endtask

    task automatic test_non_imem();
        axi_write(16'h27FF);
        vpu_push(10'h020, 2'b11, 16'hC020);
        step();
        vpu_wr_valid = 1'b0;
        #2;
        vectors++; if (ub_wr_VPU_en !== 1'b0 || axi_ubuf_en !== 1'b1) begin miscompares++; $display("[TB] FAIL imem_top_blocks got ven=%0b aen=%0b want 0/1", ub_wr_VPU_en, axi_ubuf_en); end
        step();
        axi_write(16'h2800);
        #2;
        vectors++; if (ub_wr_VPU_en !== 1'b1 || axi_ubuf_en !== 1'b1) begin miscompares++; $display("[TB] FAIL above_imem_overlap got ven=%0b aen=%0b want 1/1", ub_wr_VPU_en, axi_ubuf_en); end
        step();
        axi_write(16'h2010);
        vpu_push(10'h021, 2'b01, 16'hC021);
        step();
        vpu_wr_valid = 1'b0;
        axi_write(16'h0100);
        s_axi_wdata = 64'hDEAD_BEEF_0000_0100;
        #2;
        vectors++; if (axi_ubuf_en !== 1'b1 || ub_wr_VPU_en !== 1'b1) begin miscompares++; $display("[TB] FAIL wmem_overlap got aen=%0b ven=%0b want 1/1", axi_ubuf_en, ub_wr_VPU_en); end
        vectors++; if (axi_ubuf_addr !== 16'h0100 || axi_ubuf_we !== 1'b1 || axi_ubuf_wdata !== 64'hDEAD_BEEF_0000_0100) begin miscompares++; $display("[TB] FAIL wmem_pass got addr=%0h we=%0b data=%0h want 0100/1/deadbeef00000100", axi_ubuf_addr, axi_ubuf_we, axi_ubuf_wdata); end
        vectors++; if (ub_wr_VPU_addr_in !== 10'h021) begin miscompares++; $display("[TB] FAIL wmem_head got %0h want 021", ub_wr_VPU_addr_in); end
        step();
        axi_write(16'h2010);
        vpu_push(10'h022, 2'b01, 16'hC022);
        step();
        vpu_wr_valid = 1'b0;
        s_axi_we = 1'b0;
        #2;
        vectors++; if (axi_ubuf_en !== 1'b1 || ub_wr_VPU_en !== 1'b1) begin miscompares++; $display("[TB] FAIL imem_read_overlap got aen=%0b ven=%0b want 1/1", axi_ubuf_en, ub_wr_VPU_en); end
        step();
        idle_inputs();
        #2;
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL non_imem_empty got %0d want 0", fifo_level); end
        step();
    endtask

    task automatic test_backpressure();
        axi_write(16'h2400);
        for (int i = 0; i < 4; i++) begin
            vpu_push(10'(10'h030 + i), 2'b01, 16'(16'hD000 + i));
            #2;
            vectors++; if (vpu_wr_ready !== 1'b1 || ub_wr_VPU_en !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_accept%0d got ready=%0b en=%0b want 1/0", i, vpu_wr_ready, ub_wr_VPU_en); end
            step();
        end
        vpu_push(10'h034, 2'b01, 16'hD004);
        #2;
        vectors++; if (vpu_wr_ready !== 1'b0 || fifo_level !== 3'd4) begin miscompares++; $display("[TB] FAIL bp_full got ready=%0b lvl=%0d want 0/4", vpu_wr_ready, fifo_level); end
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #2;
            vectors++; if (ub_wr_VPU_en !== 1'b1 || ub_wr_VPU_addr_in !== 10'(10'h030 + i) || ub_wr_VPU_data_in !== mk_data(16'(16'hD000 + i))) begin miscompares++; $display("[TB] FAIL bp_drain%0d got en=%0b addr=%0h want 1/%0h", i, ub_wr_VPU_en, ub_wr_VPU_addr_in, 10'h030 + i); end
            vectors++; if (fifo_level !== 3'(4 - i)) begin miscompares++; $display("[TB] FAIL bp_level%0d got %0d want %0d", i, fifo_level, 4 - i); end
            step();
        end
        #2;
        vectors++; if (ub_wr_VPU_en !== 1'b0 || fifo_level !== 3'd0 || vpu_wr_idle !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_empty got en=%0b lvl=%0d idle=%0b want 0/0/1", ub_wr_VPU_en, fifo_level, vpu_wr_idle); end
    endtask

    task automatic test_back_to_back();
        vpu_push(10'h041, 2'b01, 16'hE041);
        step();
        vpu_push(10'h042, 2'b10, 16'hE042);
        #2;
        vectors++; if (ub_wr_VPU_en !== 1'b1 || ub_wr_VPU_addr_in !== 10'h041 || fifo_level !== 3'd1) begin miscompares++; $display("[TB] FAIL b2b_first got en=%0b addr=%0h lvl=%0d want 1/041/1", ub_wr_VPU_en, ub_wr_VPU_addr_in, fifo_level); end
        step();
        vpu_push(10'h043, 2'b11, 16'hE043);
        #2;
        vectors++; if (ub_wr_VPU_addr_in !== 10'h042 || ub_wr_VPU_size_in !== 2'b10 || fifo_level !== 3'd1) begin miscompares++; $display("[TB] FAIL b2b_second got addr=%0h size=%0b lvl=%0d want 042/10/1", ub_wr_VPU_addr_in, ub_wr_VPU_size_in, fifo_level); end
        step();
        idle_inputs();
        #2;
        vectors++; if (ub_wr_VPU_en !== 1'b1 || ub_wr_VPU_addr_in !== 10'h043 || ub_wr_VPU_data_in !== mk_data(16'hE043)) begin miscompares++; $display("[TB] FAIL b2b_third got en=%0b addr=%0h want 1/043", ub_wr_VPU_en, ub_wr_VPU_addr_in); end
        step();
    endtask

    task automatic test_noop_size();
        int seen = 0;
        vpu_push(10'h050, 2'b00, 16'hF050);
        #2;
        vectors++; if (vpu_wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL noop_ready got %0b want 1", vpu_wr_ready); end
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #2;
            if (ub_wr_VPU_en !== 1'b0 || fifo_level !== 3'd0) seen++;
            step();
        end
        vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL noop_enqueued got %0d bad cycles want 0", seen); end
    endtask

    task automatic test_reset_mid_queue();
        int seen = 0;
        axi_write(16'h2100);
        for (int i = 0; i < 3; i++) begin
            vpu_push(10'(10'h060 + i), 2'b01, 16'(16'h9060 + i));
            step();
        end
        vpu_wr_valid = 1'b0;
        #2;
        vectors++; if (fifo_level !== 3'd3) begin miscompares++; $display("[TB] FAIL mid_level got %0d want 3", fifo_level); end
        rst = 1'b1;
        #2;
        vectors++; if (ub_wr_VPU_en !== 1'b0 || s_axi_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_cycle got ven=%0b ready=%0b want 0/0", ub_wr_VPU_en, s_axi_ready); end
        step();
        rst = 1'b0;
        idle_inputs();
        #2;
        vectors++; if (fifo_level !== 3'd0 || ub_wr_VPU_en !== 1'b0 || vpu_wr_idle !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_after got lvl=%0d en=%0b idle=%0b want 0/0/1", fifo_level, ub_wr_VPU_en, vpu_wr_idle); end
        for (int i = 0; i < 5; i++) begin
            step();
            #2;
            if (ub_wr_VPU_en !== 1'b0) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL mid_stale_write got %0d writes want 0", seen); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lone_write();
        test_starvation();
        test_non_imem();
        test_backpressure();
        test_back_to_back();
        test_noop_size();
        test_reset_mid_queue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ubuf_wr_arbiter.md
# ubuf_wr_arbiter

Write-port arbiter between the AXI slave and the VPU writeback path for the unified buffer's input memory. The buffer's input memory accepts one write per cycle and silently drops a VPU write whenever an AXI write hits the IMEM range in the same cycle. This block sits directly in front of the buffer. It queues VPU writes in a small FIFO, drains them into cycles with no AXI IMEM write, and bounds VPU starvation by stalling AXI for one cycle when needed. AXI accesses to WMEM/MMEM and all AXI reads pass through with zero added latency.

## Interface
- FIFO_DEPTH, 4: VPU write queue entries (≥2).
- STARVE_LIMIT, 8: max consecutive AXI IMEM write grants while the queue is non-empty.
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- s_axi_en, s_axi_we  in  1 each  AXI-side request and write strobe.
- s_axi_addr  in  16  AXI address (IMEM = 0x2000–0x27FF).
- s_axi_wdata  in  64  AXI write data.
- s_axi_ready  out  1  AXI request accepted this cycle.
- axi_ubuf_en, axi_ubuf_we  out  1 each  to buffer.
- axi_ubuf_addr  out  16  to buffer.
- axi_ubuf_wdata  out  64  to buffer.
- vpu_wr_valid  in  1  VPU write request.
- vpu_wr_ready  out  1  queue can accept.
- vpu_wr_addr  in  10  VPU IMEM address.
- vpu_wr_size  in  2  01=128b, 10=256b, 11=512b, 00=no-op.
- vpu_wr_data  in  8 × [3:0][15:0]  VPU data.
- ub_wr_VPU_en  out  1  to buffer.
- ub_wr_VPU_addr_in  out  10  to buffer.
- ub_wr_VPU_size_in  out  2  to buffer.
- ub_wr_VPU_data_in  out  8 × [3:0][15:0]  to buffer.
- vpu_wr_idle  out  1  queue empty.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  queue occupancy.

## Operation
- Queue: circular FIFO of {addr, size, data}. Enqueue on vpu_wr_valid && vpu_wr_ready && size≠00.
- A size-00 handshake completes but is not enqueued.
- vpu_wr_ready = !rst && fifo_level < FIFO_DEPTH. There is no pass-through when full.
- imem_wr = s_axi_en && s_axi_we && addr in IMEM range.
- force = queue non-empty && starve_cnt == STARVE_LIMIT. Both force and starve_cnt are registered state.
- s_axi_ready = !rst && !force. A forced cycle stalls every AXI access, read or write, not only IMEM writes.
- axi_ubuf_en = s_axi_en && s_axi_ready. axi_ubuf_we/addr/wdata pass through combinationally.
- Drain: ub_wr_VPU_en = queue non-empty && !(imem_wr && s_axi_ready). The head is popped on the same edge.
- ub_wr_VPU_* outputs present the head entry and are all zero when the queue is empty.
- Invariant: the block never asserts ub_wr_VPU_en together with an AXI IMEM write.
- starve_cnt update, in priority order:
  - Clears to 0 on any drain cycle or when the queue is empty.
  - Otherwise increments when imem_wr is granted.
  - Otherwise holds.
  - Saturates at STARVE_LIMIT.
- Simultaneous enqueue and dequeue: level unchanged, FIFO order preserved.
- Reset mid-operation discards all entries.

## Timing
- Reset values: fifo_level=0, starve_cnt=0, vpu_wr_idle=1, ub_wr_VPU_*=0. While rst is high: s_axi_ready=0, vpu_wr_ready=0, axi_ubuf_en=0.
- AXI path: 0 cycles added. Buffer read data still returns one cycle after an accepted read.
- A stalled AXI master holds its request until s_axi_ready=1.
- VPU write accepted at edge N: earliest ub_wr_VPU_en is in cycle N→N+1, and the write lands in the buffer at edge N+1.
- Worst-case VPU head wait: STARVE_LIMIT+1 cycles.
- Draining a full queue under continuous AXI IMEM writes: FIFO_DEPTH×(STARVE_LIMIT+1) cycles.
- vpu_wr_idle and fifo_level are registered and update on the edge after an enqueue or dequeue.

## Test plan
- Lone VPU write: addr 0x005, size 01, accepted at edge 0, no AXI traffic. Required: ub_wr_VPU_en=1 in cycle 0→1 with addr 0x005, size 01; vpu_wr_idle=1 after edge 1.
- Starvation bound: one queued entry, continuous AXI writes to 0x2008, STARVE_LIMIT=8. Required: 8 AXI grants, then 1 cycle with s_axi_ready=0 and ub_wr_VPU_en=1; AXI resumes next cycle.
- Non-IMEM overlap: AXI write to 0x0100 (WMEM) while the queue is non-empty. Required: axi_ubuf_en=1 and ub_wr_VPU_en=1 in the same cycle; starve_cnt unchanged.
- Backpressure: 5 back-to-back VPU writes while AXI IMEM writes block drain. Required: first 4 accepted, fifo_level=4, vpu_wr_ready=0 on the 5th; after AXI stops, entries drain in order, one per cycle.
- No-op size: a size-00 handshake completes. Required: fifo_level stays 0 and ub_wr_VPU_en is never asserted.
- Reset mid-queue: rst pulsed for 1 cycle with 3 entries queued. Required: fifo_level=0 and ub_wr_VPU_en=0 after the edge; none of the old entries are ever written.
